// File: rtl/wb_shared_bus_pkg.sv
// rtl/wb_shared_bus_pkg.sv - shared widths, FSM encoding and width helpers for the shared bus
package wb_shared_bus_pkg;

  localparam int ADR_WIDTH = 32;
  localparam int DAT_WIDTH = 32;
  localparam int SEL_WIDTH = DAT_WIDTH / 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1,
    ST_ERRP  = 2'd2
  } bus_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int p = 1; p < value; p = p * 2) r++;
    return r;
  endfunction

  // Index of a one-entry vector still needs one bit to be a legal port.
  function automatic int idx_width(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  function automatic int cnt_width(input int timeout);
    return (timeout > 0) ? clog2(timeout + 1) : 1;
  endfunction

endpackage

// File: rtl/wb_shared_bus_if.sv
// rtl/wb_shared_bus_if.sv - Wishbone shared-bus signal bundle with master, slave and fabric views
interface wb_shared_bus_if import wb_shared_bus_pkg::*; #(
  parameter int MASTERS_NUM = 2,
  parameter int SLAVES_NUM  = 2
);

  logic [MASTERS_NUM-1:0]           m2i_cyc_i;
  logic [MASTERS_NUM-1:0]           m2i_stb_i;
  logic [MASTERS_NUM-1:0]           m2i_we_i;
  logic [MASTERS_NUM*ADR_WIDTH-1:0] m2i_adr_i;
  logic [MASTERS_NUM*DAT_WIDTH-1:0] m2i_dat_i;
  logic [MASTERS_NUM*SEL_WIDTH-1:0] m2i_sel_i;
  logic [MASTERS_NUM-1:0]           i2m_ack_o;
  logic [MASTERS_NUM-1:0]           i2m_err_o;
  logic [DAT_WIDTH-1:0]             i2m_dat_o;

  logic [SLAVES_NUM-1:0]            s2i_ack_i;
  logic [SLAVES_NUM-1:0]            s2i_err_i;
  logic [SLAVES_NUM*DAT_WIDTH-1:0]  s2i_dat_i;
  logic [SLAVES_NUM-1:0]            i2s_stb_o;
  logic                             i2s_cyc_o;
  logic                             i2s_we_o;
  logic [ADR_WIDTH-1:0]             i2s_adr_o;
  logic [DAT_WIDTH-1:0]             i2s_dat_o;
  logic [SEL_WIDTH-1:0]             i2s_sel_o;

  modport fabric (
    input  m2i_cyc_i, m2i_stb_i, m2i_we_i, m2i_adr_i, m2i_dat_i, m2i_sel_i,
    output i2m_ack_o, i2m_err_o, i2m_dat_o,
    input  s2i_ack_i, s2i_err_i, s2i_dat_i,
    output i2s_stb_o, i2s_cyc_o, i2s_we_o, i2s_adr_o, i2s_dat_o, i2s_sel_o
  );

  modport master (
    output m2i_cyc_i, m2i_stb_i, m2i_we_i, m2i_adr_i, m2i_dat_i, m2i_sel_i,
    input  i2m_ack_o, i2m_err_o, i2m_dat_o
  );

  modport slave (
    output s2i_ack_i, s2i_err_i, s2i_dat_i,
    input  i2s_stb_o, i2s_cyc_o, i2s_we_o, i2s_adr_o, i2s_dat_o, i2s_sel_o
  );

endinterface

// File: rtl/wb_rr_arbiter.sv
// rtl/wb_rr_arbiter.sv - registered round-robin grant: lowest requester at or after the pointer
module wb_rr_arbiter import wb_shared_bus_pkg::*; #(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic [N-1:0]  req_i,
  input  logic          arb_en_i,
  input  logic          release_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o
);

  logic [N-1:0]  gnt_q, gnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] sel;
  logic          found;

  always_comb begin
    found = 1'b0;
    sel   = '0;
    // First pass covers ptr..N-1, second pass wraps around to 0..ptr-1.
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j] && (IW'(j) >= ptr_q)) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end
    for (int j = 0; j < N; j++) begin
      if (!found && req_i[j]) begin
        found = 1'b1;
        sel   = IW'(j);
      end
    end

    gnt_d = gnt_q;
    idx_d = idx_q;
    ptr_d = ptr_q;
    if (arb_en_i && found) begin
      for (int j = 0; j < N; j++) gnt_d[j] = (sel == IW'(j));
      idx_d = sel;
      ptr_d = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
    end else if (release_i) begin
      gnt_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      gnt_q <= '0;
      idx_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      idx_q <= idx_d;
      ptr_q <= ptr_d;
    end
  end

  assign gnt_o     = gnt_q;
  assign gnt_idx_o = idx_q;

endmodule

// File: rtl/wb_shared_bus.sv
// rtl/wb_shared_bus.sv - N-master/M-slave Wishbone classic shared bus with decode errors and timeout
module wb_shared_bus import wb_shared_bus_pkg::*; #(
  parameter int                              MASTERS_NUM    = 2,
  parameter int                              SLAVES_NUM     = 2,
  parameter logic [SLAVES_NUM*ADR_WIDTH-1:0] SLAVE_BASE     = '0,
  parameter logic [SLAVES_NUM*ADR_WIDTH-1:0] SLAVE_MASK     = '0,
  parameter int                              TIMEOUT_CYCLES = 255
) (
  input logic             clk_i,
  input logic             rst_i,
  wb_shared_bus_if.fabric bus
);

  localparam int IDX_W = idx_width(MASTERS_NUM);
  localparam int CNT_W = cnt_width(TIMEOUT_CYCLES);
  // Compared before the increment so the error lands on stb cycle TIMEOUT_CYCLES.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT_CYCLES >= 2) ? TIMEOUT_CYCLES - 2 : 0);

  bus_state_e             state_q;
  logic                   err_q;
  logic [CNT_W-1:0]       cnt_q;

  logic [MASTERS_NUM-1:0] gnt;
  logic [IDX_W-1:0]       gnt_idx;
  logic                   owned, in_owned, active;

  logic                   m_cyc, m_stb, m_we;
  logic [ADR_WIDTH-1:0]   m_adr;
  logic [DAT_WIDTH-1:0]   m_dat;
  logic [SEL_WIDTH-1:0]   m_sel;

  logic [SLAVES_NUM-1:0]  win;
  logic                   hit_any;
  logic                   s_ack, s_err;
  logic [DAT_WIDTH-1:0]   s_dat;
  logic                   stalled, tmo_hit, unmapped;

  assign owned    = (state_q != ST_IDLE);
  assign in_owned = (state_q == ST_OWNED);

  wb_rr_arbiter #(.N(MASTERS_NUM)) u_arb (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .req_i     (bus.m2i_cyc_i),
    .arb_en_i  (state_q == ST_IDLE),
    .release_i (in_owned && !m_cyc),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx)
  );

  always_comb begin
    m_cyc = 1'b0;
    m_stb = 1'b0;
    m_we  = 1'b0;
    m_adr = '0;
    m_dat = '0;
    m_sel = '0;
    for (int j = 0; j < MASTERS_NUM; j++) begin
      if (owned && (gnt_idx == IDX_W'(j))) begin
        m_cyc = bus.m2i_cyc_i[j];
        m_stb = bus.m2i_stb_i[j];
        m_we  = bus.m2i_we_i[j];
        m_adr = bus.m2i_adr_i[j*ADR_WIDTH +: ADR_WIDTH];
        m_dat = bus.m2i_dat_i[j*DAT_WIDTH +: DAT_WIDTH];
        m_sel = bus.m2i_sel_i[j*SEL_WIDTH +: SEL_WIDTH];
      end
    end
  end

  // Lowest-numbered matching slave wins when windows overlap.
  always_comb begin
    win     = '0;
    hit_any = 1'b0;
    for (int k = 0; k < SLAVES_NUM; k++) begin
      if (owned && !hit_any &&
          ((m_adr & SLAVE_MASK[k*ADR_WIDTH +: ADR_WIDTH]) == SLAVE_BASE[k*ADR_WIDTH +: ADR_WIDTH])) begin
        win[k]  = 1'b1;
        hit_any = 1'b1;
      end
    end
  end

  always_comb begin
    s_dat = '0;
    for (int k = 0; k < SLAVES_NUM; k++) begin
      if (win[k]) s_dat = bus.s2i_dat_i[k*DAT_WIDTH +: DAT_WIDTH];
    end
  end

  assign s_ack    = |(bus.s2i_ack_i & win);
  assign s_err    = |(bus.s2i_err_i & win);
  assign active   = in_owned && m_cyc && m_stb;
  assign unmapped = active && !hit_any;
  assign stalled  = active && hit_any && !s_ack && !s_err;
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && stalled && (cnt_q == TMO_LAST);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          cnt_q <= '0;
          if (|bus.m2i_cyc_i) state_q <= ST_OWNED;
        end
        ST_OWNED: begin
          if (!m_cyc) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
          end else if (unmapped || tmo_hit) begin
            state_q <= ST_ERRP;
            err_q   <= 1'b1;
            cnt_q   <= '0;
          end else if (stalled && (TIMEOUT_CYCLES != 0)) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end else begin
            cnt_q <= '0;
          end
        end
        ST_ERRP: begin
          state_q <= ST_OWNED;
          cnt_q   <= '0;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.i2s_cyc_o = m_cyc;
  assign bus.i2s_we_o  = m_we;
  assign bus.i2s_adr_o = m_adr;
  assign bus.i2s_dat_o = m_dat;
  assign bus.i2s_sel_o = m_sel;
  assign bus.i2s_stb_o = active ? win : '0;

  assign bus.i2m_ack_o = (active && s_ack) ? gnt : '0;
  assign bus.i2m_err_o = ((active && s_err) || err_q) ? gnt : '0;
  assign bus.i2m_dat_o = s_dat;

endmodule

// File: tb/tb_wb_shared_bus.sv
// tb/tb_wb_shared_bus.sv - scoreboard bench for the 2-master/2-slave shared bus
module tb_wb_shared_bus;
  import wb_shared_bus_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc_n = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n++;

  wb_shared_bus_if #(.MASTERS_NUM(2), .SLAVES_NUM(2)) bus ();

  wb_shared_bus #(
    .MASTERS_NUM    (2),
    .SLAVES_NUM     (2),
    .SLAVE_BASE     ({32'h0000_1000, 32'h0000_0000}),
    .SLAVE_MASK     ({32'h0000_F000, 32'h0000_F000}),
    .TIMEOUT_CYCLES (4)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    int          cyc;
    logic [1:0]  ack;
    logic [1:0]  err;
    logic [1:0]  stb;
    logic [31:0] dat;
    logic [31:0] adr;
    logic        we;
  } exp_t;

  exp_t sb[$];

  logic        cyc_v[2];
  logic        stb_v[2];
  logic        we_v[2];
  logic [31:0] adr_v[2];
  logic [31:0] dat_v[2];
  logic        never_ack[2];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive();
    bus.m2i_cyc_i = {cyc_v[1], cyc_v[0]};
    bus.m2i_stb_i = {stb_v[1], stb_v[0]};
    bus.m2i_we_i  = {we_v[1], we_v[0]};
    bus.m2i_adr_i = {adr_v[1], adr_v[0]};
    bus.m2i_dat_i = {dat_v[1], dat_v[0]};
    bus.m2i_sel_i = 8'hFF;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Slave k answers data (tag ^ address); ack after two wait cycles unless muted.
  int   wait_cnt[2];
  logic [1:0] s_ack;
  initial begin
    bus.s2i_ack_i = '0;
    bus.s2i_err_i = '0;
    bus.s2i_dat_i = '0;
    wait_cnt[0] = 0;
    wait_cnt[1] = 0;
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        if (bus.i2s_stb_o[k] && !never_ack[k]) begin
          if (wait_cnt[k] == 2) begin
            s_ack[k] = 1'b1;
            wait_cnt[k] = 0;
          end else begin
            s_ack[k] = 1'b0;
            wait_cnt[k]++;
          end
        end else begin
          s_ack[k] = 1'b0;
          wait_cnt[k] = 0;
        end
      end
      bus.s2i_ack_i = s_ack;
      bus.s2i_dat_i = {32'hC3C3_0000 ^ bus.i2s_adr_o, 32'h5A5A_0000 ^ bus.i2s_adr_o};
    end
  end

  // Monitor: every ack/err presented to a master must match the next queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (|bus.i2m_ack_o || |bus.i2m_err_o) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got ack=%b err=%b at cycle %0d expected none",
                 bus.i2m_ack_o, bus.i2m_err_o, cyc_n);
      end else begin
        e = sb.pop_front();
        check({e.name, "_cycle"}, 64'(cyc_n), 64'(e.cyc));
        check({e.name, "_ack"}, 64'(bus.i2m_ack_o), 64'(e.ack));
        check({e.name, "_err"}, 64'(bus.i2m_err_o), 64'(e.err));
        check({e.name, "_slave_stb"}, 64'(bus.i2s_stb_o), 64'(e.stb));
        check({e.name, "_rdata"}, 64'(bus.i2m_dat_o), 64'(e.dat));
        check({e.name, "_adr"}, 64'(bus.i2s_adr_o), 64'(e.adr));
        check({e.name, "_we"}, 64'(bus.i2s_we_o), 64'(e.we));
      end
    end
  end

  // Issue one strobe from master m on a bus it already owns and wait for its response.
  task automatic xfer(input string name, input int m, input logic [31:0] adr, input logic we,
                      input int lat, input logic [1:0] ack, input logic [1:0] err,
                      input logic [1:0] stb, input logic [31:0] dat);
    exp_t e;
    int   n;
    logic [1:0] mbit;
    mbit = 2'b01 << m;
    adr_v[m] = adr;
    we_v[m]  = we;
    dat_v[m] = 32'hD000_0000 | adr;
    stb_v[m] = 1'b1;
    drive();
    e.name = name; e.cyc = cyc_n + lat; e.ack = ack; e.err = err;
    e.stb = stb; e.dat = dat; e.adr = adr; e.we = we;
    sb.push_back(e);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(|((bus.i2m_ack_o | bus.i2m_err_o) & mbit)) && n < 20);
    if (n >= 20) check({name, "_response_timeout"}, 64'd0, 64'd1);
    tick();
    stb_v[m] = 1'b0;
    we_v[m]  = 1'b0;
    drive();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int m = 0; m < 2; m++) begin
      cyc_v[m] = 1'b0; stb_v[m] = 1'b0; we_v[m] = 1'b0;
      adr_v[m] = '0; dat_v[m] = '0; never_ack[m] = 1'b0;
    end
    drive();
    rst = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    check("reset_cyc", 64'(bus.i2s_cyc_o), 64'd0);
    check("reset_stb", 64'(bus.i2s_stb_o), 64'd0);
    check("reset_ack", 64'(bus.i2m_ack_o), 64'd0);
    check("reset_err", 64'(bus.i2m_err_o), 64'd0);
    check("reset_rdata", 64'(bus.i2m_dat_o), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Simultaneous request with ptr=0: M0 wins after one cycle.
    cyc_v[0] = 1'b1; adr_v[0] = 32'h0000_0004;
    cyc_v[1] = 1'b1; adr_v[1] = 32'h0000_1008;
    drive();
    @(negedge clk);
    check("grant_latency_cyc", 64'(bus.i2s_cyc_o), 64'd0);
    tick();
    @(negedge clk);
    check("contest1_cyc", 64'(bus.i2s_cyc_o), 64'd1);
    check("contest1_m0_adr", 64'(bus.i2s_adr_o), 64'h0000_0004);
    tick();
    xfer("m0_read_s0", 0, 32'h0000_0004, 1'b0, 2, 2'b01, 2'b00, 2'b01, 32'h5A5A_0004);

    // M0 releases: one idle bus cycle, then M1.
    cyc_v[0] = 1'b0;
    drive();
    tick();
    @(negedge clk);
    check("handover_idle_cyc", 64'(bus.i2s_cyc_o), 64'd0);
    tick();
    @(negedge clk);
    check("handover_m1_cyc", 64'(bus.i2s_cyc_o), 64'd1);
    check("handover_m1_adr", 64'(bus.i2s_adr_o), 64'h0000_1008);
    tick();
    xfer("m1_read_s1", 1, 32'h0000_1008, 1'b0, 2, 2'b10, 2'b00, 2'b10, 32'hC3C3_1008);

    // Pointer wrapped back to 0: M0 wins the next contest.
    cyc_v[1] = 1'b0;
    drive();
    tick();
    cyc_v[0] = 1'b1; adr_v[0] = 32'h0000_8000;
    cyc_v[1] = 1'b1; adr_v[1] = 32'h0000_100C;
    drive();
    @(negedge clk);
    check("contest2_idle_cyc", 64'(bus.i2s_cyc_o), 64'd0);
    tick();
    @(negedge clk);
    check("contest2_m0_adr", 64'(bus.i2s_adr_o), 64'h0000_8000);
    tick();

    xfer("m0_unmapped", 0, 32'h0000_8000, 1'b0, 1, 2'b00, 2'b01, 2'b00, 32'h0000_0000);

    never_ack[1] = 1'b1;
    xfer("m0_timeout", 0, 32'h0000_1010, 1'b0, 3, 2'b00, 2'b01, 2'b00, 32'hC3C3_1010);
    never_ack[1] = 1'b0;

    // Burst: M1 keeps requesting but every strobe belongs to M0.
    xfer("burst0", 0, 32'h0000_0000, 1'b0, 2, 2'b01, 2'b00, 2'b01, 32'h5A5A_0000);
    xfer("burst1", 0, 32'h0000_0008, 1'b1, 2, 2'b01, 2'b00, 2'b01, 32'h5A5A_0008);
    xfer("burst2", 0, 32'h0000_1004, 1'b0, 2, 2'b01, 2'b00, 2'b10, 32'hC3C3_1004);
    cyc_v[0] = 1'b0;
    drive();
    tick();
    @(negedge clk);
    check("burst_end_idle_cyc", 64'(bus.i2s_cyc_o), 64'd0);
    tick();
    @(negedge clk);
    check("burst_end_m1_adr", 64'(bus.i2s_adr_o), 64'h0000_100C);
    tick();

    // Reset while M1 has a strobe pending: no ack, outputs drop, M0 wins afterwards.
    stb_v[1] = 1'b1;
    drive();
    @(negedge clk);
    check("pre_reset_stb", 64'(bus.i2s_stb_o), 64'b10);
    tick();
    rst = 1'b1;
    cyc_v[0] = 1'b1; adr_v[0] = 32'h0000_0020;
    drive();
    @(negedge clk);
    check("sync_reset_still_owned", 64'(bus.i2s_cyc_o), 64'd1);
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_cyc", 64'(bus.i2s_cyc_o), 64'd0);
    check("post_reset_stb", 64'(bus.i2s_stb_o), 64'd0);
    check("post_reset_ack", 64'(bus.i2m_ack_o), 64'd0);
    check("post_reset_err", 64'(bus.i2m_err_o), 64'd0);
    check("post_reset_rdata", 64'(bus.i2m_dat_o), 64'd0);
    tick();
    @(negedge clk);
    check("rearb_cyc", 64'(bus.i2s_cyc_o), 64'd1);
    check("rearb_m0_adr", 64'(bus.i2s_adr_o), 64'h0000_0020);
    check("rearb_no_stb", 64'(bus.i2s_stb_o), 64'd0);

    tick();
    for (int m = 0; m < 2; m++) begin
      cyc_v[m] = 1'b0;
      stb_v[m] = 1'b0;
    end
    drive();
    repeat (4) tick();
    @(negedge clk);
    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
